// File: rtl/operand_fetch_if.sv
// Register-index type plus the operand-fetch bus: decoded-instruction intake,
// regfile read/writeback side and the downstream operand packet.
package rvcpu;
  typedef logic [4:0] reg_t;
endpackage

interface operand_fetch_if #(
  parameter int unsigned Width = 32
);
  logic               in_valid;
  logic               in_ready;
  rvcpu::reg_t        in_rs1;
  rvcpu::reg_t        in_rs2;
  rvcpu::reg_t        in_rd;
  logic               in_rs1_valid;
  logic               in_rs2_valid;
  logic               in_rd_valid;

  rvcpu::reg_t        rs1;
  rvcpu::reg_t        rs2;
  logic               rs1_valid;
  logic               rs2_valid;
  logic [Width-1:0]   rd1;
  logic [Width-1:0]   rd2;

  logic               wb_valid;
  rvcpu::reg_t        wb_rd;
  logic [Width-1:0]   wb_val;

  logic               out_valid;
  logic               out_ready;
  logic [Width-1:0]   out_op1;
  logic [Width-1:0]   out_op2;
  rvcpu::reg_t        out_rd;
  logic               out_rd_valid;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rs1_valid, in_rs2_valid, in_rd_valid,
    output rd1, rd2, wb_valid, wb_rd, wb_val, out_ready,
    input  in_ready, rs1, rs2, rs1_valid, rs2_valid,
    input  out_valid, out_op1, out_op2, out_rd, out_rd_valid
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_valid, in_rs2_valid, in_rd_valid,
    input  rd1, rd2, wb_valid, wb_rd, wb_val, out_ready,
    output in_ready, rs1, rs2, rs1_valid, rs2_valid,
    output out_valid, out_op1, out_op2, out_rd, out_rd_valid
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboarded RAW/WAW hazard detection, writeback bypass
// and a single registered output packet with valid/ready backpressure.
module operand_fetch #(
  parameter int unsigned Width = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  output logic [15:0]         stall_count,
  operand_fetch_if.slave      bus
);

  logic [31:0]      pend;
  logic [31:0]      pend_next;
  logic             wb_live;
  logic             byp1, byp2, bypd;
  logic             haz1, haz2, hazd;
  logic             hazard;
  logic             accept;
  logic [Width-1:0] op1, op2;

  assign bus.rs1       = bus.in_rs1;
  assign bus.rs2       = bus.in_rs2;
  assign bus.rs1_valid = bus.in_valid & bus.in_rs1_valid;
  assign bus.rs2_valid = bus.in_valid & bus.in_rs2_valid;

  // A writeback to x0 neither clears the scoreboard nor forwards
  assign wb_live = bus.wb_valid & (bus.wb_rd != '0);
  assign byp1    = wb_live & (bus.wb_rd == bus.in_rs1);
  assign byp2    = wb_live & (bus.wb_rd == bus.in_rs2);
  assign bypd    = wb_live & (bus.wb_rd == bus.in_rd);

  assign haz1   = bus.in_rs1_valid & pend[bus.in_rs1] & ~byp1;
  assign haz2   = bus.in_rs2_valid & pend[bus.in_rs2] & ~byp2;
  assign hazd   = bus.in_rd_valid & (bus.in_rd != '0) & pend[bus.in_rd] & ~bypd;
  assign hazard = bus.in_valid & (haz1 | haz2 | hazd);

  assign bus.in_ready = ~hazard & ~flush & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (bus.in_rs1_valid && bus.in_rs1 != '0) op1 = byp1 ? bus.wb_val : bus.rd1;
    if (bus.in_rs2_valid && bus.in_rs2 != '0) op2 = byp2 ? bus.wb_val : bus.rd2;
  end

  // Set is applied after clear so a same-cycle issue keeps its register pending
  always_comb begin
    pend_next = pend;
    if (wb_live) pend_next[bus.wb_rd] = 1'b0;
    if (accept && bus.in_rd_valid && bus.in_rd != '0) pend_next[bus.in_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend             <= '0;
      stall_count      <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_op1      <= '0;
      bus.out_op2      <= '0;
      bus.out_rd       <= '0;
      bus.out_rd_valid <= 1'b0;
    end else begin
      if (hazard && !flush && stall_count != '1) stall_count <= stall_count + 16'd1;
      if (flush) begin
        pend          <= '0;
        bus.out_valid <= 1'b0;
      end else begin
        pend <= pend_next;
        if (accept) begin
          bus.out_valid    <= 1'b1;
          bus.out_op1      <= op1;
          bus.out_op2      <= op2;
          bus.out_rd       <= bus.in_rd;
          bus.out_rd_valid <= bus.in_rd_valid;
        end else if (bus.out_valid && bus.out_ready) begin
          bus.out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
